// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, PC step and fetch-queue entry layout.
// Entry pc is held at PC_MAX bits so one struct serves every XLEN up to 64.
package cpu_pkg;
   localparam int XLEN_DEF = 32;
   localparam int PC_MAX   = 64;
   localparam int PC_STEP  = 4;

   typedef struct packed {
      logic [PC_MAX-1:0] pc;
      logic [31:0]       inst;
      logic              filled;
   } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetched instructions.
// Entries are allocated unfilled at the tail and filled in order through a separate fill pointer.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            alloc_i,
   input  logic [XLEN-1:0] alloc_pc_i,
   input  logic            fill_i,
   input  logic [31:0]     fill_inst_i,
   input  logic            pop_i,
   output logic            valid_o,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] pc_o,
   output logic [CW-1:0]   count_o
);
   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   head_q, tail_q, fill_q;
   logic [CW-1:0]   count_q;

   assign valid_o = count_q != '0 && mem_q[head_q].filled;
   assign inst_o  = valid_o ? mem_q[head_q].inst : '0;
   assign pc_o    = valid_o ? mem_q[head_q].pc[XLEN-1:0] : '0;
   assign count_o = count_q;

   // Flush only rewinds pointers; stale filled bits are masked by count and overwritten on alloc.
   always_ff @(posedge clk_i) begin
      if (!rst_i || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else begin
         if (alloc_i) begin
            mem_q[tail_q] <= '{pc: PC_MAX'(alloc_pc_i), inst: '0, filled: 1'b0};
            tail_q        <= tail_q + 1'b1;
         end
         if (fill_i) begin
            mem_q[fill_q].inst   <= fill_inst_i;
            mem_q[fill_q].filled <= 1'b1;
            fill_q               <= fill_q + 1'b1;
         end
         if (pop_i)
            head_q <= head_q + 1'b1;
         count_q <= count_q + CW'(alloc_i) - CW'(pop_i);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with in-order memory interface and decode queue.
// Responses to requests issued before a redirect are counted down in a discard counter.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_rdy_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            inst_valid_o,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] inst_pc_o,
   input  logic            inst_ready_i
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            started_q;
   logic [CW-1:0]   live_q, live_d, disc_q, disc_d, count;
   logic [CW+1:0]   used;
   logic            accept, rsp_disc, rsp_live, pop;

   // Queue slots plus every outstanding request, live or to be discarded, bound issue.
   assign used        = (CW+2)'(count) + (CW+2)'(live_q) + (CW+2)'(disc_q);
   assign imem_req_o  = rst_i && (started_q || start_i) && !redirect_i && used < (CW+2)'(DEPTH);
   assign imem_addr_o = pc_q;
   assign accept      = imem_req_o && imem_rdy_i;
   assign rsp_disc    = imem_rvalid_i && disc_q != '0;
   assign rsp_live    = imem_rvalid_i && disc_q == '0 && live_q != '0;
   assign pop         = inst_valid_o && inst_ready_i;

   always_comb begin
      pc_d   = redirect_i ? {redirect_pc_i[XLEN-1:2], 2'b00} : accept ? pc_q + XLEN'(PC_STEP) : pc_q;
      live_d = redirect_i ? '0 : live_q + CW'(accept) - CW'(rsp_live);
      disc_d = disc_q - CW'(rsp_disc) + (redirect_i ? live_q - CW'(rsp_live) : '0);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pc_q      <= RESET_PC;
         started_q <= 1'b0;
         live_q    <= '0;
         disc_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         started_q <= started_q | start_i;
         live_q    <= live_d;
         disc_q    <= disc_d;
      end
   end

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (redirect_i),
      .alloc_i     (accept),
      .alloc_pc_i  (pc_q),
      .fill_i      (rsp_live),
      .fill_inst_i (imem_rdata_i),
      .pop_i       (pop),
      .valid_o     (inst_valid_o),
      .inst_o      (inst_o),
      .pc_o        (inst_pc_o),
      .count_o     (count)
   );
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, width of PC and instruction address.
REQ-002 Parameter DEPTH, default 4, fetch-queue entries (power of two, 2..16).
REQ-003 Parameter RESET_PC, default 0, first fetch address (word-aligned).
REQ-004 clk_i  input  1  single clock, all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-low.
REQ-006 start_i  input  1  enables fetching; sampled each cycle, latched once seen high.
REQ-007 imem_req_o  output  1  fetch request valid.
REQ-008 imem_addr_o  output  XLEN  fetch address.
REQ-009 imem_rdy_i  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid_i  input  1  response valid (in order, >=1 cycle after acceptance).
REQ-011 imem_rdata_i  input  32  response instruction word.
REQ-012 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-013 redirect_pc_i  input  XLEN  redirect target.
REQ-014 inst_valid_o  output  1  head instruction available to decode.
REQ-015 inst_o  output  32  head instruction word.
REQ-016 inst_pc_o  output  XLEN  PC of head instruction.
REQ-017 inst_ready_i  input  1  decode accepts head this cycle.

Function
REQ-018 Request accepted when imem_req_o && imem_rdy_i; fetch PC then advances by 4, modulo 2^XLEN (wrap to 0 silently).
REQ-019 imem_req_o SHALL be high only when started, no redirect this cycle, and (queue occupancy + in-flight requests) < DEPTH.
REQ-020 imem_addr_o SHALL equal the current fetch PC and stay stable while imem_req_o is high and imem_rdy_i low.
REQ-021 Each accepted request allocates a queue entry at the tail holding its PC, marked unfilled; the oldest unfilled live entry is filled by the next imem_rvalid_i.
REQ-022 inst_valid_o SHALL be high iff head entry is allocated and filled; inst_o/inst_pc_o reflect head; inst_o = 0 and inst_pc_o = 0 when not valid.
REQ-023 Transfer occurs on inst_valid_o && inst_ready_i; head pops same edge; full-queue pop and new allocation in same cycle both take effect.
REQ-024 Zero-bubble streaming: with imem_rdy_i=1, 1-cycle response latency and inst_ready_i=1, one instruction transfers per cycle in steady state.
REQ-025 redirect_i: on that edge all queue entries are invalidated, fetch PC := {redirect_pc_i[XLEN-1:2], 2'b00}, and current in-flight request count is loaded into a discard counter.
REQ-026 A transfer coinciding with redirect_i completes (decode owns it); no request is issued in a redirect cycle.
REQ-027 While discard counter > 0, each imem_rvalid_i decrements it and its data is dropped; new requests may issue meanwhile and count against DEPTH.
REQ-028 imem_rvalid_i with zero in-flight and zero discard is ignored.
REQ-029 Redirect while discard counter nonzero: counter := previous discard + current live in-flight.
REQ-030 Before start latch sets: no requests, inst_valid_o = 0; redirect still updates fetch PC.

Reset
REQ-031 With rst_i low at an edge: fetch PC := RESET_PC, queue empty, in-flight and discard counters 0, start latch cleared.
REQ-032 Reset outputs: imem_req_o 0, imem_addr_o RESET_PC, inst_valid_o 0, inst_o 0, inst_pc_o 0.
REQ-033 Reset mid-operation abandons in-flight requests; responses arriving after reset release are ignored per REQ-028.

Structure
REQ-034 Shared package cpu_pkg SHALL hold XLEN default, PC_STEP (4) and the entry struct {pc, inst, filled}.
REQ-035 The queue SHALL be a sub-module fetch_queue (DEPTH-entry circular buffer, head/tail pointers, log2(DEPTH)+1 count).

Verification
REQ-036 Reset, start_i=1, rdy=1, 1-cycle latency, ready=1 -> PCs 0,4,8,12 delivered on consecutive cycles after 2-cycle startup.
REQ-037 inst_ready_i=0, DEPTH=4 -> exactly 4 requests accepted then imem_req_o low; release ready -> 4 in-order pops, fetching resumes.
REQ-038 Two requests in flight, redirect_pc_i=0x103 -> next request address 0x100; two late responses dropped; first delivered inst_pc_o=0x100.
REQ-039 imem_rdy_i held low 5 cycles with req high -> imem_addr_o constant; no allocation until accept.
REQ-040 XLEN=8, RESET_PC=0xFC -> PCs 0xFC then 0x00 (wrap).
REQ-041 rst_i low for one cycle mid-stream with 3 in flight -> outputs at reset values, next fetch at RESET_PC after start_i, stale responses ignored.
